// File: rtl/proj_pkg.sv
// Project-wide constants shared by the FM buffer datapath blocks.
package proj_pkg;

    parameter int unsigned FM_BUFFER_SIZE = 8;

endpackage

// File: rtl/proj_fm_index_sequencer.sv
// Multi-pass FM buffer index walker: counts 0..limit (or limit..0) for a programmable
// number of passes, honouring a per-cycle stall, with per-pass and per-run completion pulses.
module proj_fm_index_sequencer #(
    parameter int unsigned DEPTH  = proj_pkg::FM_BUFFER_SIZE,
    parameter int unsigned IDX_W  = $clog2(DEPTH),
    parameter int unsigned PASS_W = 4
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_start,
    input  logic [IDX_W-1:0]  in_limit,
    input  logic [PASS_W-1:0] in_passes,
    input  logic              in_down,
    input  logic              in_stall,
    output logic [IDX_W-1:0]  index,
    output logic              index_valid,
    output logic              finished_count,
    output logic              all_done,
    output logic              busy,
    output logic [PASS_W-1:0] pass_idx
);

    localparam logic [IDX_W-1:0] LimMax = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  index_q;
    logic [IDX_W-1:0]  lim_q;
    logic [PASS_W-1:0] pass_q;
    logic [PASS_W-1:0] last_pass_q;
    logic              down_q;
    logic              busy_q;
    logic              all_done_q;

    logic [IDX_W-1:0]  start_lim;
    logic [PASS_W-1:0] start_last_pass;
    logic [IDX_W-1:0]  restart_idx;
    logic              at_end;

    always_comb begin
        start_lim       = (in_limit > LimMax) ? LimMax : in_limit;
        // A pass count of zero behaves like one, so the last pass index is zero either way.
        start_last_pass = (in_passes == '0) ? '0 : in_passes - PASS_W'(1);
        restart_idx     = down_q ? lim_q : '0;
        at_end          = down_q ? (index_q == '0) : (index_q == lim_q);
    end

    assign index_valid    = busy_q & ~in_stall;
    assign finished_count = index_valid & at_end;
    assign index          = index_q;
    assign pass_idx       = pass_q;
    assign busy           = busy_q;
    assign all_done       = all_done_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= StIdle;
            index_q     <= '0;
            lim_q       <= '0;
            pass_q      <= '0;
            last_pass_q <= '0;
            down_q      <= 1'b0;
            busy_q      <= 1'b0;
            all_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_start) begin
                        lim_q       <= start_lim;
                        last_pass_q <= start_last_pass;
                        down_q      <= in_down;
                        index_q     <= in_down ? start_lim : '0;
                        pass_q      <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (index_valid) begin
                        if (!at_end) begin
                            index_q <= down_q ? index_q - 1'b1 : index_q + 1'b1;
                        end else if (pass_q != last_pass_q) begin
                            // Next pass starts on the following cycle with no bubble.
                            index_q <= restart_idx;
                            pass_q  <= pass_q + 1'b1;
                        end else begin
                            busy_q     <= 1'b0;
                            all_done_q <= 1'b1;
                            state_q    <= StDone;
                        end
                    end
                end
                StDone: begin
                    all_done_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    busy_q     <= 1'b0;
                    all_done_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proj_fm_index_sequencer.sv
// Scoreboard bench for proj_fm_index_sequencer: a reference walk model feeds an expected queue
// that an independent monitor drains on every valid index.
module tb_proj_fm_index_sequencer;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 5;
    localparam int PASS_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_start;
    logic [IDX_W-1:0]  in_limit;
    logic [PASS_W-1:0] in_passes;
    logic              in_down;
    logic              in_stall;
    logic [IDX_W-1:0]  index;
    logic              index_valid;
    logic              finished_count;
    logic              all_done;
    logic              busy;
    logic [PASS_W-1:0] pass_idx;

    proj_fm_index_sequencer #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .PASS_W(PASS_W)
    ) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_start      (in_start),
        .in_limit      (in_limit),
        .in_passes     (in_passes),
        .in_down       (in_down),
        .in_stall      (in_stall),
        .index         (index),
        .index_valid   (index_valid),
        .finished_count(finished_count),
        .all_done      (all_done),
        .busy          (busy),
        .pass_idx      (pass_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int pass;
        bit fin;
        bit last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   done_due = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: every pass walks the clamped range once, in the requested direction.
    task automatic push_model(input int limit, input int passes, input int down);
        int lim;
        int pe;
        exp_t e;
        lim = (limit > DEPTH - 1) ? DEPTH - 1 : limit;
        pe  = (passes == 0) ? 1 : passes;
        for (int p = 0; p < pe; p++) begin
            for (int k = 0; k <= lim; k++) begin
                e.idx  = down ? lim - k : k;
                e.pass = p;
                e.fin  = (k == lim);
                e.last = (k == lim) && (p == pe - 1);
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (all_done || done_due) begin
                check("all_done_timing", int'(all_done), int'(done_due));
                if (all_done) check("busy_in_done", int'(busy), 0);
            end
            done_due = 1'b0;
            if (index_valid) begin
                if (sb.size() == 0) begin
                    flag("unexpected_valid");
                end else begin
                    mon_e = sb.pop_front();
                    check("index", int'(index), mon_e.idx);
                    check("pass_idx", int'(pass_idx), mon_e.pass);
                    check("finished_count", int'(finished_count), int'(mon_e.fin));
                    done_due = mon_e.last;
                end
            end else if (busy) begin
                check("fin_without_valid", int'(finished_count), 0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || all_done) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) flag("idle_timeout");
    endtask

    // mode: 0 no stall, 1 random stall, 2 three-cycle stall at index 2, 3 start pulses while busy
    task automatic run_seq(input int limit, input int passes, input int down, input int mode);
        int cyc = 0;
        int sc = 0;
        bit stalled = 1'b0;
        wait_idle();
        @(posedge clk);
        #1;
        in_start  = 1'b1;
        in_limit  = limit[IDX_W-1:0];
        in_passes = passes[PASS_W-1:0];
        in_down   = down[0];
        push_model(limit, passes, down);
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_stall = 1'b0;
        @(negedge clk);
        #1;
        check("start_latency", int'(index_valid), 1);
        while (!(sb.size() == 0 && !done_due && !busy && !all_done) && cyc < 1000) begin
            @(posedge clk);
            #1;
            in_start = 1'b0;
            in_stall = 1'b0;
            case (mode)
                1: in_stall = ($urandom_range(3) == 0);
                2: begin
                    if (!stalled && busy && index == 2) begin
                        sc = 3;
                        stalled = 1'b1;
                    end
                    if (sc > 0) in_stall = 1'b1;
                end
                3: if (cyc == 1 || all_done) in_start = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            #1;
            if (mode == 2 && sc > 0) begin
                check("stall_valid", int'(index_valid), 0);
                check("stall_index", int'(index), 2);
                check("stall_fin", int'(finished_count), 0);
                sc--;
            end
            cyc++;
        end
        in_start = 1'b0;
        in_stall = 1'b0;
        if (cyc >= 1000) flag("run_timeout");
        if (mode == 2 && !stalled) flag("stall_not_applied");
        check("idle_busy", int'(busy), 0);
        if (mode == 3) begin
            @(negedge clk);
            #1;
            check("no_restart_busy", int'(busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        in_start  = 1'b0;
        in_limit  = '0;
        in_passes = '0;
        in_down   = 1'b0;
        in_stall  = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        @(negedge clk);
        check("rst_index", int'(index), 0);
        check("rst_valid", int'(index_valid), 0);
        check("rst_fin", int'(finished_count), 0);
        check("rst_all_done", int'(all_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pass_idx", int'(pass_idx), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_seq(7, 1, 0, 0);
        run_seq(3, 3, 1, 0);
        run_seq(5, 1, 0, 2);
        run_seq(0, 0, 0, 0);
        run_seq(20, 1, 0, 0);
        run_seq(4, 2, 0, 3);
        for (int i = 0; i < 20; i++) begin
            run_seq(int'($urandom_range(31)), int'($urandom_range(15)),
                    int'($urandom_range(1)), 1);
        end

        // Abort a run with an asynchronous reset at index 4 of pass 1.
        wait_idle();
        @(posedge clk);
        #1;
        in_start  = 1'b1;
        in_limit  = 5'd7;
        in_passes = 4'd3;
        in_down   = 1'b0;
        push_model(7, 3, 0);
        @(posedge clk);
        #1;
        in_start = 1'b0;
        n = 0;
        while (!(pass_idx == 1 && index == 4) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) flag("reset_point_timeout");
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_index", int'(index), 0);
        check("async_valid", int'(index_valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_pass_idx", int'(pass_idx), 0);
        check("async_fin", int'(finished_count), 0);
        sb.delete();
        done_due = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("async_no_all_done", int'(all_done), 0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run_seq(7, 1, 0, 0);

        wait_idle();
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/proj_fm_index_sequencer.md
Name: proj_fm_index_sequencer

Overview:
- Parametrised, multi-pass index generator that replaces the free-running FM buffer counter.
- Walks an FM buffer index range up or down, from 0 to a runtime limit, with stall support.
- Repeats the walk for a programmable number of passes.
- Emits a per-pass end pulse and a per-run completion pulse.
- Sits between the FM buffer controller and the FM extender read/sort logic, which consume index, index_valid and finished_count.

Parameters:
- DEPTH, default proj_pkg::FM_BUFFER_SIZE: number of entries in one FM buffer. Legal range is 2 or more.
- IDX_W, default $clog2(DEPTH): width of the index bus.
- PASS_W, default 4: width of the pass-count input and the pass_idx output.

Ports:
- in_clk  input  1  clock; all logic is rising-edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_start  input  1  one-cycle start request; accepted only in IDLE.
- in_limit  input  IDX_W  last index of a pass; sampled at start.
- in_passes  input  PASS_W  number of passes; sampled at start; 0 is treated as 1.
- in_down  input  1  0 counts 0..limit; 1 counts limit..0; sampled at start.
- in_stall  input  1  holds the sequencer for the current cycle.
- index  output  IDX_W  current index.
- index_valid  output  1  index is being presented this cycle.
- finished_count  output  1  the last index of a pass is presented this cycle.
- all_done  output  1  one-cycle pulse after the final pass completes.
- busy  output  1  high in RUN.
- pass_idx  output  PASS_W  zero-based number of the current pass.

Behaviour:
- Reset (async assert, sync release): state=IDLE; index=0; index_valid=0; finished_count=0; all_done=0; busy=0; pass_idx=0; latched config=0. Reset mid-run aborts immediately, no all_done.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on in_start.
  - RUN -> DONE after the final index of the final pass is presented.
  - DONE -> IDLE unconditionally after 1 cycle.
- Start (cycle N, IDLE):
  - Latch lim = min(in_limit, DEPTH-1), passes_eff = (in_passes==0)?1:in_passes, and dir = in_down.
  - Load index = dir ? lim : 0; pass_idx = 0.
  - First valid index appears at cycle N+1 (latency 1).
- RUN:
  - busy=1.
  - index_valid = ~in_stall (combinational from in_stall).
  - When in_stall=1, index and pass_idx hold and finished_count=0.
- Advance, only when index_valid=1:
  - Up: index+1. Down: index-1.
  - At the pass end (index==lim up, index==0 down), finished_count=1 this cycle.
  - If pass_idx < passes_eff-1: next cycle reloads the start index and increments pass_idx. There is no bubble between passes.
  - Otherwise the next state is DONE.
- DONE: all_done=1 for exactly one cycle; busy=0; index_valid=0; index holds its last value.
- in_start is ignored in RUN and DONE; a start accepted in IDLE the cycle after DONE is legal.
- lim=0: every valid cycle is a pass end, so finished_count=1 on each valid index 0.
- Arithmetic:
  - The index never leaves [0, lim], so no wrap past lim or below 0.
  - The pass counter is PASS_W bits and never overflows, since passes_eff ≤ 2^PASS_W-1.
- Outputs index, pass_idx, busy and all_done are registered. index_valid and finished_count are gated combinationally by in_stall.

Test Plan:
- Basic up: DEPTH=8, start with limit=7, passes=1, down=0, no stall.
  - Required: index 0..7 valid on 8 consecutive cycles starting 1 cycle after start.
  - finished_count high only with index 7; all_done one cycle later; busy low again.
- Multi-pass down: limit=3, passes=3, down=1.
  - Required: index sequence 3,2,1,0 repeated 3 times over 12 back-to-back valid cycles.
  - finished_count high at each 0; pass_idx 0,1,2; single all_done after the third pass.
- Stall: limit=5, up, stall asserted on the cycle index=2 and held 3 cycles.
  - Required: index_valid low for 3 cycles, index stays 2, no finished_count.
  - Sequence resumes 2,3,4,5 with finished_count at 5.
- Boundaries, DEPTH=8:
  - limit=0, passes=0: exactly one valid index 0 with finished_count, then all_done.
  - limit=20: clamps, so the sequence runs 0..7.
- Start while busy: pulse in_start at the 3rd valid cycle and in DONE.
  - Required: sequence unaffected; no restart; pass_idx unaffected.
- Async reset mid-run: assert in_rst_n=0 between clock edges at index=4 of pass 1.
  - Required: outputs zero immediately without waiting for an edge; no all_done.
  - After release, a new start gives index 0 at pass_idx 0.
